// File: rtl/if_pcnext_pkg.sv
// Shared fetch-stage definitions: reset vector, PC step, FSM states and redirect entry.
package if_pcnext_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } redirect_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'd0;
    endfunction

endpackage

// File: rtl/if_pcnext_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem handshake and IF/ID outputs.
interface if_pcnext_if;

    logic        i_stallF;
    logic        i_pcsrcE;
    logic [31:0] i_addr_pcbranchE;
    logic        i_jumpD;
    logic [31:0] i_addr_pcjumpD;
    logic        i_imem_ready;

    logic [31:0] o_addr_pcF;
    logic [31:0] o_addr_pcadd4F;
    logic        o_imem_req;
    logic        o_validF;
    logic        o_flushD;
    logic        o_excp_misalign;

    modport master (
        input  i_stallF, i_pcsrcE, i_addr_pcbranchE, i_jumpD, i_addr_pcjumpD, i_imem_ready,
        output o_addr_pcF, o_addr_pcadd4F, o_imem_req, o_validF, o_flushD, o_excp_misalign
    );

    modport slave (
        output i_stallF, i_pcsrcE, i_addr_pcbranchE, i_jumpD, i_addr_pcjumpD, i_imem_ready,
        input  o_addr_pcF, o_addr_pcadd4F, o_imem_req, o_validF, o_flushD, o_excp_misalign
    );

endinterface

// File: rtl/if_redirect_buf.sv
// One-entry pending redirect: holds a branch/jump target seen while the fetch could not fire.
module if_redirect_buf
    import if_pcnext_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap_en,
    input  logic        branch_valid,
    input  logic [31:0] branch_addr,
    input  logic        jump_valid,
    input  logic [31:0] jump_addr,
    output redirect_t   pending
);

    // A later EX branch is older in program order than any decode jump, so it always wins the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (clr) begin
            pending <= '0;
        end else if (cap_en) begin
            if (branch_valid) begin
                pending <= '{valid: 1'b1, addr: branch_addr};
            end else if (jump_valid && !pending.valid) begin
                pending <= '{valid: 1'b1, addr: jump_addr};
            end
        end
    end

endmodule

// File: rtl/if_pcnext.sv
// Fetch PC sequencer: boot/fetch/error FSM, PC register and redirect selection.
module if_pcnext
    import if_pcnext_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
    input  logic          i_clk,
    input  logic          i_rst,
    if_pcnext_if.master   bus
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    redirect_t    pend;
    logic         req;
    logic         fire;
    logic         redir_any;
    logic         redir_bad;
    logic [31:0]  redir_addr;

    // Priority: EX branch, then pending entry, then decode jump.
    always_comb begin
        redir_any  = bus.i_pcsrcE | pend.valid | bus.i_jumpD;
        redir_addr = bus.i_pcsrcE ? bus.i_addr_pcbranchE :
                     pend.valid   ? pend.addr            : bus.i_addr_pcjumpD;
        redir_bad  = redir_any & is_misaligned(redir_addr);
    end

    assign req  = (state_q == ST_FETCH) & ~bus.i_stallF & ~i_rst;
    assign fire = req & bus.i_imem_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (fire && redir_bad) state_d = ST_ERR;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        bus.o_addr_pcF      = pc_q;
        bus.o_addr_pcadd4F  = pc_q + PC_STEP;
        bus.o_imem_req      = req;
        bus.o_validF        = fire & ~redir_any;
        bus.o_flushD        = fire & redir_any & ~redir_bad;
        bus.o_excp_misalign = (state_q == ST_ERR) & ~i_rst;
    end

    // A misaligned target leaves the PC untouched; the FSM moves to ERR instead.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_VECTOR;
        end else if (fire) begin
            if (!redir_any)      pc_q <= pc_q + PC_STEP;
            else if (!redir_bad) pc_q <= redir_addr;
        end
    end

    if_redirect_buf u_redirect_buf (
        .clk          (i_clk),
        .rst          (i_rst),
        .clr          (fire),
        .cap_en       ((state_q != ST_ERR) & ~fire),
        .branch_valid (bus.i_pcsrcE),
        .branch_addr  (bus.i_addr_pcbranchE),
        .jump_valid   (bus.i_jumpD),
        .jump_addr    (bus.i_addr_pcjumpD),
        .pending      (pend)
    );

endmodule

// File: tb/tb_if_pcnext.sv
// Directed bench for if_pcnext: per-cycle behavioural model plus literal PC checkpoints.
module tb_if_pcnext;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_pcnext_if bus ();

    if_pcnext #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endfunction

    // Model: where the PC is, whether we are still in the boot cycle or dead, and the redirect waiting to apply.
    logic [31:0] m_pc = 32'hBFC0_0000;
    bit          m_boot = 1'b1;
    bit          m_err  = 1'b0;
    bit          m_pv   = 1'b0;
    logic [31:0] m_pa   = '0;
    bit          e_req, e_valid, e_flush, e_excp, fire, any;
    logic [31:0] tgt;

    always begin
        @(negedge clk);
        fire = 1'b0;
        any  = 1'b0;
        tgt  = '0;
        if (rst) begin
            e_req = 1'b0; e_valid = 1'b0; e_flush = 1'b0; e_excp = 1'b0;
        end else begin
            e_req   = !m_boot && !m_err && !bus.i_stallF;
            fire    = e_req && bus.i_imem_ready;
            any     = bus.i_pcsrcE || m_pv || bus.i_jumpD;
            tgt     = bus.i_pcsrcE ? bus.i_addr_pcbranchE : (m_pv ? m_pa : bus.i_addr_pcjumpD);
            e_valid = fire && !any;
            e_flush = fire && any && (tgt % 4 == 0);
            e_excp  = m_err;
        end
        chk32("pcF", bus.o_addr_pcF, m_pc);
        chk32("pcadd4F", bus.o_addr_pcadd4F, m_pc + 32'd4);
        chk1("imem_req", bus.o_imem_req, e_req);
        chk1("validF", bus.o_validF, e_valid);
        chk1("flushD", bus.o_flushD, e_flush);
        chk1("excp_misalign", bus.o_excp_misalign, e_excp);
        if (rst) begin
            m_pc = 32'hBFC0_0000; m_boot = 1'b1; m_err = 1'b0; m_pv = 1'b0; m_pa = '0;
        end else if (m_err) begin
            m_pv = 1'b0;
        end else if (fire) begin
            if (!any)             m_pc = m_pc + 32'd4;
            else if (tgt % 4 == 0) m_pc = tgt;
            else                  m_err = 1'b1;
            m_pv = 1'b0;
        end else begin
            if (bus.i_pcsrcE) begin
                m_pv = 1'b1; m_pa = bus.i_addr_pcbranchE;
            end else if (bus.i_jumpD && !m_pv) begin
                m_pv = 1'b1; m_pa = bus.i_addr_pcjumpD;
            end
            m_boot = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pc_is(input string name, input logic [31:0] lit);
        chk32(name, bus.o_addr_pcF, lit);
        chk32({name, "_model"}, m_pc, lit);
    endtask

    initial begin
        bus.i_stallF = 1'b0; bus.i_pcsrcE = 1'b0; bus.i_addr_pcbranchE = '0;
        bus.i_jumpD = 1'b0; bus.i_addr_pcjumpD = '0; bus.i_imem_ready = 1'b1;

        step(2);
        pc_is("reset_pc", 32'hBFC0_0000);
        chk1("reset_req", bus.o_imem_req, 1'b0);
        rst = 1'b0;
        step(1);
        pc_is("boot_pc", 32'hBFC0_0000);
        chk1("first_fire_valid", bus.o_validF, 1'b1);
        step(1); pc_is("seq_pc1", 32'hBFC0_0004);
        step(1); pc_is("seq_pc2", 32'hBFC0_0008);

        bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0100; #1;
        chk1("jump_flush", bus.o_flushD, 1'b1);
        step(1); bus.i_jumpD = 1'b0;
        pc_is("jump_pc", 32'h0000_0100);
        bus.i_pcsrcE = 1'b1; bus.i_addr_pcbranchE = 32'h0000_0040; #1;
        chk1("branch_flush", bus.o_flushD, 1'b1);
        chk1("branch_valid", bus.o_validF, 1'b0);
        step(1); bus.i_pcsrcE = 1'b0;
        pc_is("branch_pc", 32'h0000_0040);

        bus.i_imem_ready = 1'b0; bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0200; #1;
        chk1("notready_flush", bus.o_flushD, 1'b0);
        step(1); bus.i_jumpD = 1'b0;
        pc_is("notready_pc1", 32'h0000_0040);
        step(2); pc_is("notready_pc3", 32'h0000_0040);
        bus.i_imem_ready = 1'b1; #1;
        chk1("pending_flush", bus.o_flushD, 1'b1);
        chk1("pending_valid", bus.o_validF, 1'b0);
        step(1); pc_is("pending_jump_pc", 32'h0000_0200);

        bus.i_imem_ready = 1'b0; bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0200;
        step(1); bus.i_jumpD = 1'b0; bus.i_pcsrcE = 1'b1; bus.i_addr_pcbranchE = 32'h0000_0300;
        step(1); bus.i_pcsrcE = 1'b0; bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0400;
        step(1); bus.i_jumpD = 1'b0; bus.i_imem_ready = 1'b1;
        step(1); pc_is("branch_overwrites_pc", 32'h0000_0300);

        bus.i_pcsrcE = 1'b1; bus.i_addr_pcbranchE = 32'h0000_0500;
        bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0600;
        step(1); bus.i_pcsrcE = 1'b0; bus.i_jumpD = 1'b0;
        pc_is("branch_over_jump_pc", 32'h0000_0500);

        bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0010;
        step(1); bus.i_jumpD = 1'b0;
        pc_is("pre_stall_pc", 32'h0000_0010);
        bus.i_stallF = 1'b1; #1;
        chk1("stall_req", bus.o_imem_req, 1'b0);
        step(2); pc_is("stall_hold_pc", 32'h0000_0010);
        bus.i_stallF = 1'b0;
        step(1); pc_is("post_stall_pc", 32'h0000_0014);
        bus.i_stallF = 1'b1; bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0020;
        step(1); bus.i_jumpD = 1'b0;
        step(1); pc_is("stall_capture_pc", 32'h0000_0014);
        bus.i_stallF = 1'b0;
        step(1); pc_is("stall_pending_pc", 32'h0000_0020);

        bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'hFFFF_FFFC;
        step(1); bus.i_jumpD = 1'b0;
        pc_is("top_pc", 32'hFFFF_FFFC);
        chk32("wrap_add4", bus.o_addr_pcadd4F, 32'h0000_0000);
        step(1); pc_is("wrap_pc", 32'h0000_0000);
        chk1("wrap_no_excp", bus.o_excp_misalign, 1'b0);

        bus.i_imem_ready = 1'b0; bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0080;
        step(1); bus.i_jumpD = 1'b0; rst = 1'b1; #1;
        chk1("rst_flush", bus.o_flushD, 1'b0);
        step(1); rst = 1'b0; bus.i_imem_ready = 1'b1;
        pc_is("rst_abandon_pc", 32'hBFC0_0000);
        step(2); pc_is("rst_no_pending_pc", 32'hBFC0_0004);

        bus.i_pcsrcE = 1'b1; bus.i_addr_pcbranchE = 32'h0000_0102; #1;
        chk1("misalign_flush", bus.o_flushD, 1'b0);
        step(1); bus.i_pcsrcE = 1'b0;
        chk1("misalign_excp", bus.o_excp_misalign, 1'b1);
        chk1("misalign_req", bus.o_imem_req, 1'b0);
        pc_is("misalign_pc", 32'hBFC0_0004);
        bus.i_jumpD = 1'b1; bus.i_addr_pcjumpD = 32'h0000_0040;
        step(3); bus.i_jumpD = 1'b0;
        chk1("err_sticky", bus.o_excp_misalign, 1'b1);
        pc_is("err_pc", 32'hBFC0_0004);
        rst = 1'b1;
        step(1); rst = 1'b0;
        chk1("err_cleared", bus.o_excp_misalign, 1'b0);
        step(1);
        chk1("post_err_req", bus.o_imem_req, 1'b1);
        step(2);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_pcnext.md
IF_PCNEXT -- requirements
Module: if_pcnext

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_stallF  input  1  hazard-unit fetch stall; PC holds while high.
REQ-005 i_pcsrcE  input  1  EX-stage branch taken.
REQ-006 i_addr_pcbranchE  input  32  EX-stage branch target (pcadd4E + shifted immediate).
REQ-007 i_jumpD  input  1  decode-stage jump.
REQ-008 i_addr_pcjumpD  input  32  decode-stage jump target.
REQ-009 i_imem_ready  input  1  instruction memory accepts/completes the current request.
REQ-010 o_addr_pcF  output  32  current fetch PC, driven to imem.
REQ-011 o_addr_pcadd4F  output  32  o_addr_pcF + 4, to IF/ID.
REQ-012 o_imem_req  output  1  fetch request valid.
REQ-013 o_validF  output  1  fetched instruction is valid for IF/ID capture.
REQ-014 o_flushD  output  1  one-cycle pulse: squash the IF/ID contents.
REQ-015 o_excp_misalign  output  1  sticky misaligned-target error.

Function
REQ-016 FSM states SHALL be BOOT, FETCH, ERR; BOOT->FETCH after exactly one cycle; FETCH->ERR on a misaligned redirect; ERR exits only on reset.
REQ-017 o_imem_req SHALL equal (state==FETCH) & !i_stallF; fire = o_imem_req & i_imem_ready.
REQ-018 Redirect priority SHALL be: EX branch > pending redirect > decode jump > sequential.
REQ-019 A redirect present in a non-fire cycle SHALL be captured in a one-entry pending register (valid + 32-bit address); an EX branch overwrites the entry, a jump loads it only if empty.
REQ-020 On fire, the PC SHALL load the highest-priority redirect target if any exists (live or pending), else o_addr_pcF + 4, and the pending entry SHALL be cleared.
REQ-021 o_validF SHALL be high in a fire cycle only when no redirect (live or pending) exists; an in-flight fetch overtaken by a redirect is discarded.
REQ-022 o_flushD SHALL pulse high for the single cycle in which a redirect is applied to the PC.
REQ-023 A redirect target with bits[1:0] != 0 SHALL not load the PC; the FSM enters ERR, o_excp_misalign goes high and stays high, and o_imem_req stays low.
REQ-024 While i_stallF is high, PC, pending entry (except new captures per REQ-019) and state SHALL hold.
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no error.
REQ-026 Branch and jump asserted together SHALL select the branch; the jump is dropped.

Reset
REQ-027 On i_rst: state=BOOT, o_addr_pcF=RESET_VECTOR, pending cleared, o_imem_req=0, o_validF=0, o_flushD=0, o_excp_misalign=0.
REQ-028 Reset asserted mid-fetch or while pending SHALL abandon the fetch and pending redirect with no flush pulse.

Structure
REQ-029 FSM state enum and RESET_VECTOR default SHALL live in the shared processor package.
REQ-030 The pending-redirect register SHALL be a sub-module named if_redirect_buf; the FSM and PC register stay in if_pcnext.

Verification
REQ-031 Reset, ready=1, no stall -> PC 32'hBFC0_0000, BFC0_0004, BFC0_0008 on successive cycles after BOOT, o_validF=1 each fire.
REQ-032 PC=32'h0000_0100, pcsrcE=1 with target 32'h0000_0040 in a fire cycle -> next PC 32'h0000_0040, o_flushD=1 one cycle, o_validF=0 that cycle.
REQ-033 ready=0 for 3 cycles, jumpD=1 (target 32'h0000_0200) in cycle 1 -> no PC change until ready; on fire PC=32'h0000_0200, flush pulse, o_validF=0.
REQ-034 Pending jump 32'h200 then branch 32'h300 before fire -> PC=32'h300.
REQ-035 Branch target 32'h0000_0102 -> ERR, o_excp_misalign=1 held, o_imem_req=0; i_rst clears it.
REQ-036 stall=1 for 2 cycles at PC 32'h0000_0010 -> o_imem_req=0, PC holds; after release PC advances to 32'h0000_0014.
